tune_ctrl: RTL and testbench

//  Front-panel tuning controller; drives the NCO phase_inc word directly, replacing raw button polling.

---
 rtl/tune_ctrl.sv | 143 ++++++++++++++
 tb/tb_tune_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tune_ctrl.sv
// tune_ctrl: debounced button tuning of the NCO phase increment with auto-repeat, clamping and preset load
module tune_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter logic [39:0] FINE_STEP       = 40'h110c6f7,
    parameter logic [39:0] COARSE_STEP     = 40'h1346dc5d,
    parameter logic [39:0] RESET_INC       = 40'h2656abde3,
    parameter logic [39:0] MIN_INC         = 40'h17f62b6ae,
    parameter logic [39:0] MAX_INC         = 40'h47ae147ae1
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        preset_load,
    input  logic [39:0] preset_value,
    output logic [39:0] phase_inc,
    output logic        step_tick,
    output logic        at_limit
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SCW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCW-1:0] DELAY_LAST = SCW'(REPEAT_DELAY - 1);
    localparam logic [SCW-1:0] PERIOD_LAST = SCW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

    // Bit order everywhere: {right, left, down, up}
    logic [3:0]          btn_raw;
    logic [3:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]          db_q, db_d;
    logic [3:0][DCW-1:0] db_cnt_q, db_cnt_d;
    state_t              state_q, state_d;
    logic [3:0]          held_q, held_d;
    logic [SCW-1:0]      step_cnt_q, step_cnt_d;
    logic [39:0]         phase_inc_q, phase_inc_d;
    logic                step_tick_q, step_tick_d;
    logic                at_limit_q, at_limit_d;
    logic                valid_press, hold_ok, step_req, step_sub;
    logic [39:0]         step_amt, stepped;
    logic [40:0]         sum, diff;

    assign btn_raw     = {btn_right, btn_left, btn_down, btn_up};
    assign valid_press = $onehot(db_q);
    assign hold_ok     = (db_q == held_q);
    assign phase_inc   = phase_inc_q;
    assign step_tick   = step_tick_q;
    assign at_limit    = at_limit_q;

    function automatic logic [39:0] clamp(input logic [40:0] v);
        return (v < {1'b0, MIN_INC}) ? MIN_INC : (v > {1'b0, MAX_INC}) ? MAX_INC : v[39:0];
    endfunction

    // All state registers, including the button synchronisers
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_cnt_q    <= '0;
            state_q     <= S_IDLE;
            held_q      <= '0;
            step_cnt_q  <= '0;
            phase_inc_q <= RESET_INC;
            step_tick_q <= 1'b0;
            at_limit_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            held_q      <= held_d;
            step_cnt_q  <= step_cnt_d;
            phase_inc_q <= phase_inc_d;
            step_tick_q <= step_tick_d;
            at_limit_q  <= at_limit_d;
        end
    end

    // Two-stage synchroniser and per-button stability counters
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d     = db_q;
        db_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                db_d[i]     = (db_cnt_q[i] == DB_LAST) ? sync2_q[i] : db_q[i];
                db_cnt_d[i] = (db_cnt_q[i] == DB_LAST) ? '0 : db_cnt_q[i] + 1'b1;
            end
        end
    end

    // Repeat FSM next state: any change of the debounced set ends a hold
    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        step_cnt_d = step_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (valid_press) begin
                    state_d    = S_DELAY;
                    held_d     = db_q;
                    step_cnt_d = '0;
                end
            end
            S_DELAY: begin
                state_d    = !hold_ok ? S_IDLE : (step_cnt_q == DELAY_LAST) ? S_REPEAT : S_DELAY;
                step_cnt_d = (!hold_ok || step_cnt_q == DELAY_LAST) ? '0 : step_cnt_q + 1'b1;
            end
            S_REPEAT: begin
                state_d    = hold_ok ? S_REPEAT : S_IDLE;
                step_cnt_d = (!hold_ok || step_cnt_q == PERIOD_LAST) ? '0 : step_cnt_q + 1'b1;
            end
            default: begin
                state_d    = S_IDLE;
                step_cnt_d = '0;
            end
        endcase
    end

    // FSM outputs and saturating phase datapath; a preset overrides any step
    always_comb begin
        step_req = (state_q == S_IDLE)   ? valid_press :
                   (state_q == S_DELAY)  ? hold_ok && (step_cnt_q == DELAY_LAST) :
                   (state_q == S_REPEAT) ? hold_ok && (step_cnt_q == PERIOD_LAST) : 1'b0;
        step_amt = (db_q[0] | db_q[1]) ? COARSE_STEP : FINE_STEP;
        step_sub = db_q[1] | db_q[3];
        sum      = {1'b0, phase_inc_q} + {1'b0, step_amt};
        diff     = {1'b0, phase_inc_q} - {1'b0, step_amt};
        stepped  = (step_sub && diff[40]) ? MIN_INC : clamp(step_sub ? diff : sum);
        phase_inc_d = preset_load ? clamp({1'b0, preset_value}) : step_req ? stepped : phase_inc_q;
        step_tick_d = (phase_inc_d != phase_inc_q);
        at_limit_d  = (phase_inc_d == MIN_INC) || (phase_inc_d == MAX_INC);
    end

endmodule

// File: tb/tb_tune_ctrl.sv
// tb_tune_ctrl: directed/randomised button and preset sequences checked against a timing-rule model
module tb_tune_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam logic [39:0] FINE   = 40'h110c6f7;
    localparam logic [39:0] COARSE = 40'h1346dc5d;
    localparam logic [39:0] RST_V  = 40'h2656abde3;
    localparam logic [39:0] MIN_V  = 40'h17f62b6ae;
    localparam logic [39:0] MAX_V  = 40'h47ae147ae1;
    localparam logic [3:0] UP = 4'b0001, DOWN = 4'b0010, LEFT = 4'b0100, RIGHT = 4'b1000;

    logic        CLK = 1'b0;
    logic        RSTb = 1'b1;
    logic [3:0]  raw = '0;
    logic        preset_load = 1'b0;
    logic [39:0] preset_value = '0;
    logic [39:0] phase_inc;
    logic        step_tick, at_limit;

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_phase;

    tune_ctrl #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .CLK(CLK), .RSTb(RSTb),
        .btn_up(raw[0]), .btn_down(raw[1]), .btn_left(raw[2]), .btn_right(raw[3]),
        .preset_load(preset_load), .preset_value(preset_value),
        .phase_inc(phase_inc), .step_tick(step_tick), .at_limit(at_limit)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] clamp(input longint v);
        if (v < longint'(MIN_V)) return MIN_V;
        if (v > longint'(MAX_V)) return MAX_V;
        return v[39:0];
    endfunction

    function automatic logic [39:0] step_model(input logic [3:0] b, input logic [39:0] p);
        longint amt = (b[0] | b[1]) ? longint'(COARSE) : longint'(FINE);
        return clamp((b[1] | b[3]) ? longint'(p) - amt : longint'(p) + amt);
    endfunction

    // Drive button set b for h edges, observe for n edges; optional preset pulse active at edge pk+1.
    // Steps land at edges DB+2, DB+2+RD, then every RP, while the release has not yet debounced (k <= h+DB+1).
    task automatic hold_seq(input logic [3:0] b, input int h, input int n, input int pk, input logic [39:0] pv);
        logic [39:0] nxt;
        bit dec;
        raw = b;
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
            dec = (h >= DB) && (k <= h + DB + 1) &&
                  (k == DB + 2 || (k >= DB + 2 + RD && (k - (DB + 2 + RD)) % RP == 0));
            nxt = exp_phase;
            if (k == pk + 1) nxt = clamp(longint'(pv));
            else if (dec) nxt = step_model(b, exp_phase);
            check("step_tick", 40'(step_tick), 40'(nxt != exp_phase));
            exp_phase = nxt;
            check("phase_inc", phase_inc, exp_phase);
            check("at_limit", 40'(at_limit), 40'(exp_phase == MIN_V || exp_phase == MAX_V));
            preset_load  = (k == pk);
            preset_value = pv;
            if (k == h - 1) raw = '0;
        end
        preset_load = 1'b0;
    endtask

    task automatic do_preset(input logic [39:0] v);
        logic [39:0] nxt;
        preset_value = v;
        preset_load  = 1'b1;
        @(posedge CLK);
        #1;
        preset_load = 1'b0;
        nxt = clamp(longint'(v));
        check("preset_tick", 40'(step_tick), 40'(nxt != exp_phase));
        exp_phase = nxt;
        check("preset_phase", phase_inc, exp_phase);
        check("preset_limit", 40'(at_limit), 40'(exp_phase == MIN_V || exp_phase == MAX_V));
    endtask

    initial begin
        int h;
        logic [39:0] v;
        exp_phase = RST_V;
        #3 RSTb = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_phase", phase_inc, RST_V);
        check("reset_tick", 40'(step_tick), 40'(0));
        check("reset_limit", 40'(at_limit), 40'(0));
        RSTb = 1'b1;
        hold_seq('0, 0, 100, -10, '0);

        hold_seq(LEFT, 3, 20, -10, '0);
        check("glitch3_phase", phase_inc, RST_V);
        hold_seq(LEFT, 6, 20, -10, '0);
        check("glitch6_phase", phase_inc, RST_V + FINE);

        h = $urandom_range(60, 100);
        hold_seq(UP, h, h + 12, -10, '0);

        raw = UP | DOWN;
        for (int k = 0; k < 60; k++) begin
            @(posedge CLK);
            #1;
            check("dual_tick", 40'(step_tick), 40'(0));
            check("dual_phase", phase_inc, exp_phase);
        end
        h = $urandom_range(40, 70);
        hold_seq(UP, h, h + 12, -10, '0);

        v = 40'(longint'(MIN_V) + longint'($urandom) % (longint'(MAX_V) - longint'(MIN_V)));
        hold_seq(LEFT, 40, 52, DB + 1, v);

        for (int i = 0; i < 6; i++) do_preset({$urandom_range(0, 255), $urandom} & 40'hFFFFFFFFFF);

        do_preset(MIN_V);
        hold_seq(RIGHT, 40, 52, -10, '0);
        check("min_phase", phase_inc, MIN_V);
        do_preset(40'hFFFFFFFFFF);
        check("max_phase", phase_inc, MAX_V);
        hold_seq(LEFT, 30, 42, -10, '0);

        hold_seq(DOWN, 1000, 35, -10, '0);
        #2 RSTb = 1'b0;
        #1;
        exp_phase = RST_V;
        check("midhold_rst_phase", phase_inc, RST_V);
        check("midhold_rst_tick", 40'(step_tick), 40'(0));
        check("midhold_rst_limit", 40'(at_limit), 40'(0));
        repeat (3) @(posedge CLK);
        #1 RSTb = 1'b1;
        hold_seq(DOWN, 40, 52, -10, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
